ahbdefaultsub: RTL and testbench
================================

# ahbdefaultsub

AHB-Lite default subordinate that answers every bus transfer no memory region claims. The PMA checker faults core-side accesses to unmapped space before they reach the bus. This block covers the bus side: any transfer that still arrives at an unmapped address (from a debug module, DMA or other manager) gets a protocol-correct two-cycle ERROR response. It also logs the offending address for software. The block sits in the uncore beside the address decoder and is selected when no other region decodes.

## Interface

Parameters
- P: cvw_t configuration; supplies P.PA_BITS.
- COUNT_BITS: 8; width of the saturating error counter.

Ports
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- HSELDefault  input  1  decoder select; asserted when no region matches HADDR.
- HADDR  input  P.PA_BITS  address-phase address.
- HWRITE  input  1  address-phase write flag.
- HTRANS  input  2  transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HREADY  input  1  global ready, already muxed from all subordinates.
- HREADYDefault  output  1  this subordinate's HREADYOUT.
- HRESPDefault  output  1  this subordinate's HRESP; 0=OKAY, 1=ERROR.
- ErrClear  input  1  one-cycle pulse that clears the log.
- ErrValid  output  1  at least one error logged since reset or the last clear.
- ErrAddr  output  P.PA_BITS  address of the most recent erroring transfer.
- ErrWrite  output  1  HWRITE of the most recent erroring transfer.
- ErrCount  output  COUNT_BITS  number of erroring transfers, saturating.

## Operation

- Accept = HSELDefault & HTRANS[1] & HREADY.
  - Only NONSEQ and SEQ transfers are accepted.
  - IDLE and BUSY transfers get a zero-wait OKAY response and are never logged.
- The FSM has three states: IDLE, ERR1, ERR2.
  - IDLE: if Accept, go to ERR1; otherwise stay in IDLE.
  - ERR1: unconditionally go to ERR2. HREADY is low in ERR1, so Accept cannot occur there.
  - ERR2: if Accept (back-to-back transfer), go to ERR1; otherwise go to IDLE.
- Outputs are decoded from state only (Moore):
  - HREADYDefault = (state != ERR1).
  - HRESPDefault = (state == ERR1) | (state == ERR2).
- Log update on Accept:
  - ErrAddr is loaded with HADDR and ErrWrite with HWRITE.
  - ErrValid is set to 1.
  - ErrCount is incremented, saturating at 2^COUNT_BITS−1 (no wrap).
- ErrClear with no Accept in the same cycle: ErrValid←0 and ErrCount←0. ErrAddr and ErrWrite hold their values.
- ErrClear and Accept in the same cycle: ErrValid←1, ErrCount←1, and ErrAddr/ErrWrite take the new transfer.
- The log holds its value while ErrValid=1; newer errors overwrite ErrAddr (last-error semantics).
- Write data is ignored. HRDATA is not driven by this block; the top-level mux returns zero for this region.

## Timing

- Reset (synchronous):
  - state=IDLE, HREADYDefault=1, HRESPDefault=0.
  - ErrValid=0, ErrAddr=0, ErrWrite=0, ErrCount=0.
- Reset asserted mid-response (ERR1 or ERR2): the next edge returns the FSM to IDLE and drops the response. Reset overrides Accept and ErrClear.
- Error response for a transfer accepted at edge N:
  - Cycle N+1: HREADYDefault=0, HRESPDefault=1 (first ERROR cycle).
  - Cycle N+2: HREADYDefault=1, HRESPDefault=1 (second ERROR cycle).
  - Cycle N+3: HREADYDefault=1, HRESPDefault=0, unless a back-to-back transfer was accepted in N+2.
- Log latency: the log registers update at edge N, so ErrValid, ErrAddr and ErrCount are visible in cycle N+1.
- Throughput: sustained back-to-back errors complete one transfer every 2 cycles (ERR1/ERR2 alternating).
- A manager that cancels its pipelined transfer during ERR1 (by driving IDLE in ERR2) causes no further response.

## Structure

- Shared cvw package: HTRANS encoding constants (HTRANS_IDLE, HTRANS_NONSEQ, etc.), since they are common to all AHB subordinates.
- The FSM state enum is local to this module.
- One natural sub-module: satcounter #(WIDTH), a saturating counter with synchronous reset, clear and increment inputs. It is reusable by other error and performance logs.
- No other hierarchy.

## Test plan

- Reset, then NONSEQ read with HSELDefault=1, HADDR=0x8000_1000, HREADY=1 -> next cycle HREADYDefault=0/HRESPDefault=1; following cycle 1/1; then 1/0. ErrValid=1, ErrAddr=0x8000_1000, ErrWrite=0, ErrCount=1.
- IDLE and BUSY transfers with HSELDefault=1 -> HREADYDefault stays 1, HRESPDefault stays 0, ErrCount stays 0.
- Back-to-back NONSEQ write 0x10 accepted, then SEQ write 0x14 accepted in ERR2 -> response sequence ERR1, ERR2, ERR1, ERR2. ErrAddr=0x14, ErrWrite=1, ErrCount=2.
- With COUNT_BITS=2, five erroring transfers -> ErrCount reads 1, 2, 3, 3, 3 (saturates, no wrap).
- ErrClear pulsed in the same cycle as an Accept of 0x20 -> ErrCount=1, ErrValid=1, ErrAddr=0x20. ErrClear alone afterwards -> ErrCount=0, ErrValid=0, ErrAddr stays 0x20.
- Reset asserted during ERR1 -> next cycle state is IDLE, HREADYDefault=1, HRESPDefault=0, all log outputs 0.

Source files
------------

// File: rtl/ahbdefaultsub_pkg.sv
// ahbdefaultsub_pkg
//   Shared definitions for the AHB-Lite default subordinate slice:
//   the core configuration record (cvw_t) and the AHB HTRANS encodings
//   common to every AHB subordinate.
package ahbdefaultsub_pkg;

    typedef struct packed {
        int unsigned PA_BITS;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{PA_BITS: 32};

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // True for transfer types that demand a data-phase response.
    function automatic logic isActiveTrans(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahbdefaultsub_if.sv
// ahbdefaultsub_if
//   AHB-Lite signals seen by the default subordinate.
//   HSELDefault, HADDR, HWRITE, HTRANS, HREADY : manager/decoder -> subordinate
//   HREADYDefault, HRESPDefault                : subordinate -> bus mux
interface ahbdefaultsub_if #(
    parameter int unsigned PA_BITS = 32
);
    logic               HSELDefault;
    logic [PA_BITS-1:0] HADDR;
    logic               HWRITE;
    logic [1:0]         HTRANS;
    logic               HREADY;
    logic               HREADYDefault;
    logic               HRESPDefault;

    modport master (
        output HSELDefault, HADDR, HWRITE, HTRANS, HREADY,
        input  HREADYDefault, HRESPDefault
    );

    modport slave (
        input  HSELDefault, HADDR, HWRITE, HTRANS, HREADY,
        output HREADYDefault, HRESPDefault
    );
endinterface

// File: rtl/ahbdefaultsub_satcounter.sv
// satcounter
//   Saturating up-counter with synchronous reset, clear and increment.
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the count (if inc is also set, count restarts at 1)
//   inc        : add one, holding at all-ones
//   count      : current value
module satcounter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] countNext;

    always_comb begin
        countNext = count;
        if (clear) begin
            countNext = inc ? WIDTH'(1) : '0;
        end else if (inc && (count != '1)) begin
            countNext = count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else       count <= countNext;
    end

endmodule

// File: rtl/ahbdefaultsub.sv
// ahbdefaultsub
//   AHB-Lite default subordinate: gives every accepted NONSEQ/SEQ transfer
//   a two-cycle ERROR response and logs the last offending transfer.
//   clk, reset    : single clock, synchronous active-high reset
//   ahb (slave)   : HSELDefault/HADDR/HWRITE/HTRANS/HREADY in,
//                   HREADYDefault/HRESPDefault out
//   ErrClear      : one-cycle pulse clearing ErrValid and ErrCount
//   ErrValid      : an error was logged since reset/clear
//   ErrAddr       : HADDR of the most recent erroring transfer
//   ErrWrite      : HWRITE of the most recent erroring transfer
//   ErrCount      : saturating count of erroring transfers
module ahbdefaultsub
    import ahbdefaultsub_pkg::*;
#(
    parameter cvw_t        P          = CVW_DEFAULT,
    parameter int unsigned COUNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    ahbdefaultsub_if.slave        ahb,
    input  logic                  ErrClear,
    output logic                  ErrValid,
    output logic [P.PA_BITS-1:0]  ErrAddr,
    output logic                  ErrWrite,
    output logic [COUNT_BITS-1:0] ErrCount
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ERR1 = 2'b01,
        ERR2 = 2'b10
    } state_t;

    state_t state, stateNext;
    logic   accept;

    assign accept = ahb.HSELDefault & isActiveTrans(ahb.HTRANS) & ahb.HREADY;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = IDLE;
        unique case (state)
            IDLE:    stateNext = accept ? ERR1 : IDLE;
            ERR1:    stateNext = ERR2;
            ERR2:    stateNext = accept ? ERR1 : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Moore outputs: stall only in the first ERROR cycle.
    assign ahb.HREADYDefault = (state != ERR1);
    assign ahb.HRESPDefault  = (state == ERR1) || (state == ERR2);

    // Error log. Address/write hold across a clear; only valid/count reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ErrValid <= 1'b0;
            ErrAddr  <= '0;
            ErrWrite <= 1'b0;
        end else if (accept) begin
            ErrValid <= 1'b1;
            ErrAddr  <= ahb.HADDR;
            ErrWrite <= ahb.HWRITE;
        end else if (ErrClear) begin
            ErrValid <= 1'b0;
        end
    end

    satcounter #(.WIDTH(COUNT_BITS)) errCounter (
        .clk   (clk),
        .reset (reset),
        .clear (ErrClear),
        .inc   (accept),
        .count (ErrCount)
    );

endmodule

// File: tb/tb_ahbdefaultsub.sv
// tb_ahbdefaultsub
//   Table-driven check of the default subordinate. Two instances share the
//   same stimulus: one with the default 8-bit counter, one with a 2-bit
//   counter to observe saturation.
module tb_ahbdefaultsub;
    import ahbdefaultsub_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic ErrClear;

    always #5 clk = ~clk;

    ahbdefaultsub_if #(.PA_BITS(32)) bus8 ();
    ahbdefaultsub_if #(.PA_BITS(32)) bus2 ();

    assign bus2.HSELDefault = bus8.HSELDefault;
    assign bus2.HADDR       = bus8.HADDR;
    assign bus2.HWRITE      = bus8.HWRITE;
    assign bus2.HTRANS      = bus8.HTRANS;
    assign bus2.HREADY      = bus8.HREADY;

    logic        errValid8, errWrite8, errValid2, errWrite2;
    logic [31:0] errAddr8, errAddr2;
    logic [7:0]  errCount8;
    logic [1:0]  errCount2;

    ahbdefaultsub #(.P(CVW_DEFAULT), .COUNT_BITS(8)) dut8 (
        .clk(clk), .reset(reset), .ahb(bus8), .ErrClear(ErrClear),
        .ErrValid(errValid8), .ErrAddr(errAddr8), .ErrWrite(errWrite8),
        .ErrCount(errCount8)
    );

    ahbdefaultsub #(.P(CVW_DEFAULT), .COUNT_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .ahb(bus2), .ErrClear(ErrClear),
        .ErrValid(errValid2), .ErrAddr(errAddr2), .ErrWrite(errWrite2),
        .ErrCount(errCount2)
    );

    typedef struct {
        logic        rst, sel;
        logic [1:0]  tr;
        logic        rdy;
        logic [31:0] addr;
        logic        wr, clr;
        logic        eRdy, eResp, eValid;
        logic [31:0] eAddr;
        logic        eWr;
        logic [7:0]  eC8;
        logic [1:0]  eC2;
    } vec_t;

    typedef struct {
        logic        eRdy, eResp, eValid;
        logic [31:0] eAddr;
        logic        eWr;
        logic [7:0]  eC8;
        logic [1:0]  eC2;
    } exp_t;

    exp_t scoreboard[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        input logic rst, input logic sel, input logic [1:0] tr, input logic rdy,
        input logic [31:0] addr, input logic wr, input logic clr,
        input logic eRdy, input logic eResp, input logic eValid,
        input logic [31:0] eAddr, input logic eWr,
        input logic [7:0] eC8, input logic [1:0] eC2);
        vec_t v;
        v.rst = rst; v.sel = sel; v.tr = tr; v.rdy = rdy; v.addr = addr;
        v.wr = wr; v.clr = clr; v.eRdy = eRdy; v.eResp = eResp;
        v.eValid = eValid; v.eAddr = eAddr; v.eWr = eWr; v.eC8 = eC8; v.eC2 = eC2;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, push its expectation, then compare the
    // outputs visible in the cycle after the edge.
    task automatic step(input vec_t v, input int idx);
        exp_t e, got;
        reset            = v.rst;
        bus8.HSELDefault = v.sel;
        bus8.HTRANS      = v.tr;
        bus8.HREADY      = v.rdy;
        bus8.HADDR       = v.addr;
        bus8.HWRITE      = v.wr;
        ErrClear         = v.clr;
        e.eRdy = v.eRdy; e.eResp = v.eResp; e.eValid = v.eValid;
        e.eAddr = v.eAddr; e.eWr = v.eWr; e.eC8 = v.eC8; e.eC2 = v.eC2;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            errors++;
            $display("FAIL scoreboard step %0d: got empty queue, expected an entry", idx);
            return;
        end
        got = scoreboard.pop_front();
        check("HREADYDefault", idx, 32'(bus8.HREADYDefault), 32'(got.eRdy));
        check("HRESPDefault",  idx, 32'(bus8.HRESPDefault),  32'(got.eResp));
        check("ErrValid",      idx, 32'(errValid8),          32'(got.eValid));
        check("ErrAddr",       idx, errAddr8,                got.eAddr);
        check("ErrWrite",      idx, 32'(errWrite8),          32'(got.eWr));
        check("ErrCount8",     idx, 32'(errCount8),          32'(got.eC8));
        check("ErrCount2",     idx, 32'(errCount2),          32'(got.eC2));
        check("HRESP2",        idx, 32'(bus2.HRESPDefault),  32'(got.eResp));
        check("ErrAddr2",      idx, errAddr2,                got.eAddr);
    endtask

    vec_t tbl[24];

    initial begin
        //            rst sel tr    rdy addr          wr clr  rdyO rsp val eAddr         eWr c8 c2
        tbl[0]  = mk(1, 0, 2'b00, 1, 32'h0,        0, 0,   1, 0, 0, 32'h0,        0, 0, 0);
        tbl[1]  = mk(0, 1, 2'b00, 1, 32'h100,      0, 0,   1, 0, 0, 32'h0,        0, 0, 0); // IDLE
        tbl[2]  = mk(0, 1, 2'b01, 1, 32'h104,      1, 0,   1, 0, 0, 32'h0,        0, 0, 0); // BUSY
        tbl[3]  = mk(0, 1, 2'b10, 1, 32'h8000_1000,0, 0,   0, 1, 1, 32'h8000_1000,0, 1, 1); // ERR1
        tbl[4]  = mk(0, 1, 2'b00, 0, 32'h0,        0, 0,   1, 1, 1, 32'h8000_1000,0, 1, 1); // ERR2
        tbl[5]  = mk(0, 1, 2'b00, 1, 32'h0,        0, 0,   1, 0, 1, 32'h8000_1000,0, 1, 1); // done
        tbl[6]  = mk(0, 1, 2'b10, 1, 32'h10,       1, 0,   0, 1, 1, 32'h10,       1, 2, 2);
        tbl[7]  = mk(0, 1, 2'b11, 0, 32'h14,       1, 0,   1, 1, 1, 32'h10,       1, 2, 2);
        tbl[8]  = mk(0, 1, 2'b11, 1, 32'h14,       1, 0,   0, 1, 1, 32'h14,       1, 3, 3); // b2b
        tbl[9]  = mk(0, 1, 2'b10, 0, 32'h18,       0, 0,   1, 1, 1, 32'h14,       1, 3, 3);
        tbl[10] = mk(0, 1, 2'b10, 1, 32'h18,       0, 0,   0, 1, 1, 32'h18,       0, 4, 3); // sat
        tbl[11] = mk(0, 1, 2'b10, 0, 32'h1C,       0, 0,   1, 1, 1, 32'h18,       0, 4, 3);
        tbl[12] = mk(0, 1, 2'b10, 1, 32'h1C,       0, 0,   0, 1, 1, 32'h1C,       0, 5, 3);
        tbl[13] = mk(0, 1, 2'b10, 0, 32'h24,       0, 0,   1, 1, 1, 32'h1C,       0, 5, 3);
        tbl[14] = mk(0, 1, 2'b00, 1, 32'h24,       0, 0,   1, 0, 1, 32'h1C,       0, 5, 3); // cancel
        tbl[15] = mk(0, 0, 2'b10, 1, 32'h28,       1, 0,   1, 0, 1, 32'h1C,       0, 5, 3); // unsel
        tbl[16] = mk(0, 1, 2'b10, 0, 32'h2C,       1, 0,   1, 0, 1, 32'h1C,       0, 5, 3); // !HREADY
        tbl[17] = mk(0, 1, 2'b10, 1, 32'h20,       0, 1,   0, 1, 1, 32'h20,       0, 1, 1); // clr+acc
        tbl[18] = mk(0, 1, 2'b00, 0, 32'h0,        0, 0,   1, 1, 1, 32'h20,       0, 1, 1);
        tbl[19] = mk(0, 1, 2'b00, 1, 32'h0,        0, 1,   1, 0, 0, 32'h20,       0, 0, 0); // clr
        tbl[20] = mk(0, 1, 2'b11, 1, 32'h30,       1, 0,   0, 1, 1, 32'h30,       1, 1, 1);
        tbl[21] = mk(1, 1, 2'b10, 0, 32'h34,       1, 1,   1, 0, 0, 32'h0,        0, 0, 0); // rst@ERR1
        tbl[22] = mk(0, 1, 2'b00, 1, 32'h0,        0, 0,   1, 0, 0, 32'h0,        0, 0, 0);
        tbl[23] = mk(0, 0, 2'b00, 1, 32'h0,        0, 0,   1, 0, 0, 32'h0,        0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < 24; i++) step(tbl[i], i);

        // Sustained back-to-back errors, then reset in ERR2 with a pending accept.
        step(mk(0, 1, 2'b10, 1, 32'h40, 0, 0,  0, 1, 1, 32'h40, 0, 1, 1), 100);
        step(mk(0, 1, 2'b11, 0, 32'h44, 1, 0,  1, 1, 1, 32'h40, 0, 1, 1), 101);
        step(mk(0, 1, 2'b11, 1, 32'h44, 1, 0,  0, 1, 1, 32'h44, 1, 2, 2), 102);
        step(mk(0, 1, 2'b11, 0, 32'h48, 0, 0,  1, 1, 1, 32'h44, 1, 2, 2), 103);
        step(mk(0, 1, 2'b11, 1, 32'h48, 0, 0,  0, 1, 1, 32'h48, 0, 3, 3), 104);
        step(mk(0, 1, 2'b11, 0, 32'h4C, 1, 0,  1, 1, 1, 32'h48, 0, 3, 3), 105);
        step(mk(1, 1, 2'b11, 1, 32'h4C, 1, 1,  1, 0, 0, 32'h0,  0, 0, 0), 106);
        step(mk(0, 0, 2'b00, 1, 32'h0,  0, 0,  1, 0, 0, 32'h0,  0, 0, 0), 107);

        if (scoreboard.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d leftover, expected 0", scoreboard.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1);
    end

endmodule
